// File: rtl/reg_file_2r1w.sv
// ----------------------------------------------------------------------------
// reg_file_2r1w
//   Parametrised operand register file with two independent registered read
//   ports and one write port. Two operands can be read every cycle while a
//   result is written back. Entry 0 can be hardwired to zero, and a read that
//   hits the entry being written in the same cycle can optionally see the
//   new data.
//
// Parameters
//   DATA_W   width of each entry, bits
//   ADDR_W   address width; depth = 2**ADDR_W
//   ZERO_REG 1: entry 0 reads 0 and ignores writes
//   BYPASS   1: same-cycle write data is forwarded to a colliding read
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous reset, active-high; clears file and outputs
//   we, waddr, wdata    write port
//   re_a, raddr_a       read request, port A
//   rdata_a, rvalid_a   registered read data and its one-cycle valid strobe
//   re_b, raddr_b       read request, port B
//   rdata_b, rvalid_b   registered read data and its one-cycle valid strobe
// ----------------------------------------------------------------------------
module reg_file_2r1w #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              write_ok;
    logic [DATA_W-1:0] next_a;
    logic [DATA_W-1:0] next_b;

    // Writes to the hardwired-zero entry are dropped.
    assign write_ok = we && !((ZERO_REG != 0) && (waddr == '0));

    // Read-data selection per port. The zero-register rule is applied last so
    // it overrides the bypass path on an address-0 collision.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_a = mem[raddr_a];
        if ((BYPASS != 0) && we && (raddr_a == waddr)) begin
            next_a = wdata;
        end
        if ((ZERO_REG != 0) && (raddr_a == '0)) begin
            next_a = '0;
        end
    end

    always_comb begin
        next_b = mem[raddr_b];
        if ((BYPASS != 0) && we && (raddr_b == waddr)) begin
            next_b = wdata;
        end
        if ((ZERO_REG != 0) && (raddr_b == '0)) begin
            next_b = '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; this is what makes BYPASS=0 return the old
    // contents on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the whole array is cleared because the file must read 0
            // after reset; this prevents mapping onto a RAM macro without
            // reset, which is acceptable for a small operand store.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata_a  <= '0;
            rdata_b  <= '0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            if (write_ok) begin
                mem[waddr] <= wdata;
            end
            rvalid_a <= re_a;
            rvalid_b <= re_b;
            if (re_a) begin
                rdata_a <= next_a;
            end
            if (re_b) begin
                rdata_b <= next_b;
            end
        end
    end

endmodule
